// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if
// Bundles the requester side (req / req_data / gnt) and the downstream
// send/ready link (so / do_data / ro) of one router output channel.
//   req      N     requester i holds a valid packet
//   req_data N*DW  flattened packets, requester i at [i*DW +: DW]
//   gnt      N     one-hot pop strobe back to the requesters
//   so       1     output buffer holds a valid packet
//   do_data  DW    output packet
//   ro       1     downstream ready
// master: the arbiter itself.  slave: the surrounding router/environment.
interface noc_output_arbiter_if #(
    parameter int DW = 64,
    parameter int N  = 4
);
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            so;
    logic [DW-1:0]   do_data;
    logic            ro;

    modport master (
        input  req, req_data, ro,
        output gnt, so, do_data
    );

    modport slave (
        output req, req_data, ro,
        input  gnt, so, do_data
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Round-robin arbiter plus single-entry output buffer for one router output
// channel.  Only requests whose packet VC bit (bit DW-1) matches the current
// network polarity are eligible.  The winner is popped (gnt) and its packet
// captured into the output buffer, which is drained over the so/ro link.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high; clears buffer and pointer
//   polarity  current network phase
//   bus       noc_output_arbiter_if.master (req/req_data/gnt, so/do_data/ro)
module noc_output_arbiter #(
    parameter int DW = 64,
    parameter int N  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    noc_output_arbiter_if.master  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [DW-1:0]   do_reg;

    logic [N-1:0]    elig;
    logic            any_elig;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   ptr_next;
    logic            accept;
    logic            capture;

    // A request counts only when its packet travels on the current VC.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign elig[gi] = bus.req[gi] &&
                              (bus.req_data[gi*DW + DW - 1] == polarity);
        end
    endgenerate

    // Scan ptr, ptr+1, ... wrapping; first eligible index wins.
    always_comb begin
        int          idx;
        logic [PW-1:0] cand;
        any_elig = 1'b0;
        winner   = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PW'(idx);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    assign ptr_next = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;

    // The buffer can take a packet if it is empty or drains on this edge.
    assign accept  = (state_reg == EMPTY) || bus.ro;
    assign capture = accept && any_elig && !reset;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign bus.gnt[gi] = capture && (winner == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            do_reg    <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (capture) begin
                        state_reg <= FULL;
                        do_reg    <= bus.req_data[winner*DW +: DW];
                        ptr_reg   <= ptr_next;
                    end
                end
                FULL: begin
                    // capture implies ro here: old packet leaves, new one loads.
                    if (capture) begin
                        do_reg  <= bus.req_data[winner*DW +: DW];
                        ptr_reg <= ptr_next;
                    end else if (bus.ro) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign bus.so      = (state_reg == FULL);
    assign bus.do_data = do_reg;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Testbench for noc_output_arbiter: directed scenarios with inline gnt/so/do
// comparisons, plus a scoreboard of expected packets popped whenever the
// output link transfers (so && ro).
module tb_noc_output_arbiter;
    localparam int DW = 64;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic reset;
    logic polarity;
    logic [DW-1:0] data [N];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_output_arbiter_if #(.DW(DW), .N(N)) bus ();

    noc_output_arbiter #(.DW(DW), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .bus      (bus)
    );

    // Scoreboard: every transfer edge must deliver the oldest expected packet.
    always @(negedge clk) begin
        logic [DW-1:0] exp_pkt;
        #2;
        if (!reset && bus.so && bus.ro) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: transfer of %h with no packet expected", bus.do_data);
            end else begin
                exp_pkt = exp_q.pop_front();
                if (bus.do_data !== exp_pkt) begin
                    errors++;
                    $display("FAIL sb_data: got %h want %h", bus.do_data, exp_pkt);
                end else begin
                    $display("xfer ok: %h", bus.do_data);
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic p, input logic rdy);
        @(negedge clk);
        bus.req  = r;
        polarity = p;
        bus.ro   = rdy;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data[i];
        #1;
    endtask

    task automatic test_reset();
        data[0]      = 64'h0000_0000_0000_1234;
        for (int i = 1; i < N; i++) data[i] = '0;
        reset        = 1'b1;
        polarity     = 1'b0;
        bus.ro       = 1'b1;
        bus.req      = 4'b0001;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data[i];
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.so !== 1'b0 || bus.do_data !== 64'h0 || bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: so=%b do=%h gnt=%b want 0/0/0", bus.so, bus.do_data, bus.gnt);
        end
        $display("reset: so=%b do=%h gnt=%b", bus.so, bus.do_data, bus.gnt);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_contention();
        logic [N-1:0] reqs [6];
        logic [N-1:0] gnts [6];
        int           wins [6];
        reqs = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1001, 4'b1000};
        gnts = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
        wins = '{0, 1, 2, 3, 0, 3};
        data[0] = 64'h0010_0000_00ab_cdef;
        data[1] = 64'h0010_0000_1234_5678;
        data[2] = 64'h0010_0000_00de_f123;
        data[3] = 64'h0010_0000_0001_1a11;
        for (int s = 0; s < 6; s++) begin
            if (s == 4) begin
                data[0] = 64'h0010_0000_0a0a_0a0a;
                data[3] = 64'h0010_0000_3b3b_3b3b;
            end
            drive(reqs[s], 1'b0, 1'b1);
            checks++;
            if (bus.gnt !== gnts[s]) begin
                errors++;
                $display("FAIL contention_gnt%0d: got %b want %b", s, bus.gnt, gnts[s]);
            end
            $display("contention step %0d: req=%b gnt=%b", s, reqs[s], bus.gnt);
            exp_q.push_back(data[wins[s]]);
        end
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        checks++;
        if (bus.so !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain: so=%b want 0", bus.so);
        end
    endtask

    task automatic test_single();
        data[0] = 64'h2002_0000_0000_FA50;
        drive(4'b0001, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: got %b want 0001", bus.gnt);
        end
        exp_q.push_back(data[0]);
        drive('0, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.so !== 1'b1 || bus.do_data !== 64'h2002_0000_0000_FA50) begin
            errors++;
            $display("FAIL single_out: gnt=%b so=%b do=%h want 0000/1/2002_0000_0000_fa50", bus.gnt, bus.so, bus.do_data);
        end
        drive('0, 1'b0, 1'b1);
        checks++;
        if (bus.so !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: so=%b want 0", bus.so);
        end
        $display("single: done");
    endtask

    task automatic test_polarity();
        data[2] = 64'h4012_0000_0000_ffff;
        drive(4'b0100, 1'b1, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.so !== 1'b0) begin
            errors++;
            $display("FAIL polarity_block: gnt=%b so=%b want 0000/0", bus.gnt, bus.so);
        end
        drive(4'b0100, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL polarity_gnt: got %b want 0100", bus.gnt);
        end
        exp_q.push_back(data[2]);
        drive('0, 1'b1, 1'b1);
        checks++;
        if (bus.so !== 1'b1 || bus.do_data !== 64'h4012_0000_0000_ffff) begin
            errors++;
            $display("FAIL polarity_out: so=%b do=%h", bus.so, bus.do_data);
        end
        drive('0, 1'b0, 1'b1);
        $display("polarity: done");
    endtask

    task automatic test_fairness();
        data[0] = 64'h0000_0000_0000_0f0f;
        data[3] = 64'h0000_0000_0000_3030;
        drive(4'b1001, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL fair_gnt3: got %b want 1000", bus.gnt);
        end
        exp_q.push_back(data[3]);
        drive(4'b0001, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL fair_gnt0: got %b want 0001", bus.gnt);
        end
        exp_q.push_back(data[0]);
        // ptr must now be 1: requester 1 beats requester 0.
        data[0] = 64'h0000_0000_0000_00a0;
        data[1] = 64'h0000_0000_0000_00b1;
        drive(4'b0011, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL fair_ptr1: got %b want 0010", bus.gnt);
        end
        exp_q.push_back(data[1]);
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        $display("fairness: done");
    endtask

    task automatic test_backpressure();
        data[0] = 64'h0002_0000_0005_3fda;
        data[1] = 64'h0002_0000_0001_1111;
        drive(4'b0001, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL bp_fill: got %b want 0001", bus.gnt);
        end
        exp_q.push_back(data[0]);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 1'b0, 1'b0);
            checks++;
            if (bus.gnt !== 4'b0000 || bus.so !== 1'b1 || bus.do_data !== 64'h0002_0000_0005_3fda) begin
                errors++;
                $display("FAIL bp_stall%0d: gnt=%b so=%b do=%h", c, bus.gnt, bus.so, bus.do_data);
            end
        end
        drive(4'b0010, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_b2b_gnt: got %b want 0010", bus.gnt);
        end
        exp_q.push_back(data[1]);
        drive('0, 1'b0, 1'b0);
        checks++;
        if (bus.so !== 1'b1 || bus.do_data !== 64'h0002_0000_0001_1111) begin
            errors++;
            $display("FAIL bp_b2b_out: so=%b do=%h", bus.so, bus.do_data);
        end
        $display("backpressure: done");
    endtask

    task automatic test_reset_mid();
        data[0] = 64'h0000_0000_0000_0c00;
        data[1] = 64'h0000_0000_0000_0c01;
        data[2] = 64'h0000_0000_0000_0c02;
        data[3] = 64'h0000_0000_0000_0c03;
        drive(4'b1111, 1'b0, 1'b0);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_full_gnt: got %b want 0000", bus.gnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.so !== 1'b0 || bus.do_data !== 64'h0 || bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_clear: so=%b do=%h gnt=%b", bus.so, bus.do_data, bus.gnt);
        end
        exp_q.delete();
        bus.req = '0;
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 1'b0, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr0: got %b want 0001", bus.gnt);
        end
        exp_q.push_back(data[0]);
        drive('0, 1'b0, 1'b1);
        $display("reset_mid: done");
    endtask

    task automatic test_throughput();
        int grants = 0;
        logic p;
        data[0] = 64'h0000_0000_0000_7000;
        for (int c = 0; c < 6; c++) begin
            p = (c % 2 == 0);
            drive(4'b0001, p, 1'b1);
            checks++;
            if (bus.gnt !== (p ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL thru_gnt%0d: got %b pol=%b", c, bus.gnt, p);
            end
            if (bus.gnt[0]) begin
                grants++;
                exp_q.push_back(data[0]);
                data[0] = data[0] + 64'd1;
            end
        end
        drive('0, 1'b0, 1'b1);
        checks++;
        if (grants != 3) begin
            errors++;
            $display("FAIL thru_count: got %0d want 3", grants);
        end
        drive('0, 1'b1, 1'b1);
        $display("throughput: %0d grants in 6 cycles", grants);
    endtask

    task automatic test_random();
        logic          so_m = 1'b0;
        int            ptr_m = 0;
        logic          p = 1'b0;
        logic [N-1:0]  r;
        logic          rdy;
        logic          found;
        int            win;
        int            idx;
        logic [N-1:0]  exp_g;
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) data[i] = {$urandom_range(0, 1) == 1, 31'($urandom), 32'($urandom)};
        for (int c = 0; c < 60; c++) begin
            r   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            p   = ~p;
            drive(r, p, rdy);
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (!found && r[idx] && data[idx][DW-1] == p) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            exp_g = '0;
            if ((!so_m || rdy) && found) exp_g[win] = 1'b1;
            checks++;
            if (bus.gnt !== exp_g || bus.so !== so_m) begin
                errors++;
                $display("FAIL rand%0d: gnt=%b so=%b want %b/%b", c, bus.gnt, bus.so, exp_g, so_m);
            end
            if (exp_g != '0) begin
                exp_q.push_back(data[win]);
                so_m  = 1'b1;
                ptr_m = (win + 1) % N;
                data[win] = {$urandom_range(0, 1) == 1, 31'($urandom), 32'($urandom)};
            end else if (so_m && rdy) begin
                so_m = 1'b0;
            end
        end
        drive('0, ~p, 1'b1);
        drive('0, p, 1'b1);
        checks++;
        if (exp_q.size() != 0 || bus.so !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: %0d packets left, so=%b", exp_q.size(), bus.so);
        end
        $display("random: done");
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_polarity();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_throughput();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Round-robin arbiter and single-entry output buffer for one router output channel (CW, CCW, PE, NS or SN). It shares the channel among up to N input virtual-channel buffers and considers only packets whose VC bit matches the current network polarity. It hands the winner's 64-bit packet to the downstream send/ready link. One instance sits in front of each output port of the router.

## Interface
- DW, 64, packet width in bits; bit DW-1 is the packet's VC (polarity) bit.
- N, 4, number of requesters; pointer width is clog2(N).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- polarity  in  1  current network phase from the router; toggles every cycle in normal operation.
- req  in  N  req[i]=1: requester i holds a valid packet.
- req_data  in  N*DW  flattened packets; requester i at [i*DW +: DW].
- gnt  out  N  one-hot pop strobe; gnt[i]=1 in the cycle requester i's packet is captured, and requester i dequeues on that edge.
- so  out  1  send-out: output buffer holds a valid packet.
- do  out  DW  output packet, passed through unmodified.
- ro  in  1  downstream ready; transfer occurs on any edge with so && ro.

## Operation
- Eligibility: elig[i] = req[i] && (req_data[i*DW+DW-1] == polarity). Ineligible requests are ignored for that cycle. They are not dropped and not counted.
- Output buffer has two states, EMPTY (so=0) and FULL (so=1).
- accept = EMPTY || (so && ro), i.e. the buffer is empty or drains this edge.
- Capture happens when accept && |elig. The winner is the first eligible index found scanning ptr, ptr+1, …, wrapping N-1→0.
- On capture:
  - do <= winner data
  - state <= FULL
  - ptr <= (winner+1) mod N
- FULL && ro && no capture → EMPTY. do holds its last value and is don't-care when so=0.
- FULL && !ro → hold do, so, ptr; gnt=0.
- FULL && ro && capture: back-to-back. The old packet leaves and the new one loads on the same edge, state stays FULL.
- gnt is combinational from state, ptr, req, req_data, polarity, ro. It is at most one-hot and is 0 whenever accept=0 or no request is eligible.
- ptr advances only on a grant. It never advances on idle cycles or on cycles with mismatched polarity.

## Timing
- Reset values: so=0, do=0, ptr=0, state EMPTY. gnt=0 while reset is asserted.
- Reset mid-operation discards any buffered packet immediately (so falls asynchronously). Requesters see no gnt, so nothing they hold is lost.
- Latency: gnt in cycle t → so=1 and do=packet from edge t+1.
- Throughput:
  - At most one capture per cycle.
  - With ro held at 1, a continuously eligible stream is accepted every cycle.
  - With polarity toggling and all packets on one VC, one packet is accepted every 2 cycles.
- ro is sampled only at the edge. Deasserting ro stalls without loss; so/do are stable until the transfer edge.
- Simultaneous requests resolve strictly round-robin. Any requester that stays eligible is granted within N grants.

## Test plan
- Reset: assert reset mid-packet with so=1 → so=0, do=0, gnt=0 at once; after release the first grant goes to requester 0 (ptr=0).
- Single request: req=4'b0001, data0=64'h200200000000FA50, polarity=0 (bit63=0), ro=1 → gnt=4'b0001 in cycle t; so=1, do=64'h200200000000FA50 at t+1; so=0 at t+2.
- Polarity filter: req[2] with data 64'h401200000000ffff (bit63=0) while polarity=1 → gnt=0; when polarity flips to 0 → gnt=4'b0100 and the packet appears one cycle later.
- Four-way contention: req=4'b1111, all packets VC=0 (64'h0010000000abcdef, …12345678, …00def123, …00011a11), polarity held 0, ro=1 → grants 0,1,2,3 on consecutive cycles, do follows in the same order, and ptr wraps to 0.
- Backpressure: buffer FULL with 64'h0002000000053fda, ro=0 for 3 cycles with req[1] eligible → gnt=0 and do stable; on the edge where ro=1, the old packet transfers and req[1] is captured on the same edge (so stays 1).
- Fairness after wrap: ptr=3 with req=4'b1001 → gnt=4'b1000; next accept → gnt=4'b0001; ptr=1.
